// File: rtl/rom_rd_pkg.sv
// Shared defaults and FSM encoding for the ROM burst reader.
package rom_rd_pkg;

  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ROM_LAT  = 3;
  localparam int DEF_FIFO_DEP = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rom_rd_fifo.sv
// Synchronous show-ahead FIFO: head word is always visible on dout.
// DEPTH must be a power of two so the pointers wrap naturally.
module rom_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             full;
  logic             pop_ok;

  assign empty  = (cnt == '0);
  assign full   = (cnt == (AW+1)'(DEPTH));
  assign pop_ok = pop && !empty;
  assign dout   = mem[rd_ptr];
  assign count  = cnt;

  // Storage, pointers and occupancy; push+pop together leaves occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // A push into a full FIFO without a matching pop means the credit accounting upstream is broken.
  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop_ok))
    else $error("rom_rd_fifo: push while full");

endmodule

// File: rtl/rom_reader.sv
// Burst read initiator for a pipelined ROM: issues one address per cycle under
// a credit limit, tracks the fixed read latency with a valid shift register and
// streams the returned bytes in order through a show-ahead FIFO.
// Optional running checksum of delivered bytes: define ROM_RD_CHECKSUM_EN.
module rom_reader
  import rom_rd_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ROM_LAT  = DEF_ROM_LAT,
  parameter int FIFO_DEP = DEF_FIFO_DEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [DATA_W-1:0] csum
);

  localparam int CNT_W  = $clog2(FIFO_DEP) + 1;
  localparam int IF_W   = $clog2(ROM_LAT + 2);
  localparam int CRED_W = $clog2(FIFO_DEP + ROM_LAT + 2) + 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q;
  logic [ADDR_W:0]     rem_q;
  // vld_p[0] lines up with rom_addr, vld_p[ROM_LAT] lines up with rom_dout
  logic [ROM_LAT:0]    vld_p;
  logic [IF_W-1:0]     inflight;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                fifo_empty;
  logic                push, pop, issue, accept, credit_ok;

  assign push    = vld_p[ROM_LAT];
  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;

  // Number of issued reads whose data has not yet landed in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= ROM_LAT; i++) inflight = inflight + IF_W'(vld_p[i]);
  end

  // A slot freed by this cycle's pop is usable immediately, so a streaming
  // consumer sees one byte per cycle once the pipeline has filled.
  assign credit_ok = (CRED_W'(fifo_cnt) + CRED_W'(inflight)) < (CRED_W'(FIFO_DEP) + CRED_W'(pop));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and control outputs.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    accept  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept  = 1'b1;
          state_d = (len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        issue = credit_ok;
        if (credit_ok && rem_q == (ADDR_W+1)'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty && inflight == '0) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address counter, remaining count, registered ROM address and latency tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q    <= '0;
      rem_q    <= '0;
      rom_addr <= '0;
      vld_p    <= '0;
    end else begin
      if (accept) begin
        cur_q <= base;
        rem_q <= len;
      end else if (issue) begin
        rom_addr <= cur_q;
        cur_q    <= cur_q + ADDR_W'(1);
        rem_q    <= rem_q - (ADDR_W+1)'(1);
      end
      vld_p <= {vld_p[ROM_LAT-1:0], issue};
    end
  end

  rom_rd_fifo #(
    .DEPTH (FIFO_DEP),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rom_dout),
    .pop   (pop),
    .dout  (m_data),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

`ifdef ROM_RD_CHECKSUM_EN
  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] b);
    return acc + b;
  endfunction

  logic [DATA_W-1:0] csum_q;

  // Running modular sum of delivered bytes, restarted by each accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         csum_q <= '0;
    else if (accept) csum_q <= '0;
    else if (pop)    csum_q <= csum_add(csum_q, m_data);
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_rom_reader.sv
// Self-checking bench for rom_reader with a behavioural model of the 16x8
// pipelined ROM (three address flops) and a queue-based expected stream.
`timescale 1ns/1ps
module tb_rom_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] base;
  logic [4:0] len;
  logic       busy, done;
  logic [3:0] rom_addr;
  logic [7:0] rom_dout;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [7:0] csum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rom_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .csum     (csum)
  );

  // ROM contents
  function automatic logic [7:0] rom_byte(input logic [3:0] a);
    if (a <= 4'd6)      return 8'h10 + {4'h0, a};
    else if (a == 4'hF) return 8'h1F;
    else                return 8'h00;
  endfunction

  // ROM pipeline: three address flops, then the array lookup
  logic [3:0] ra1 = '0, ra2 = '0, ra3 = '0;
  always @(posedge clk) begin
    ra1 <= rom_addr;
    ra2 <= ra1;
    ra3 <= ra2;
  end
  assign rom_dout = rom_byte(ra3);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // cycle counter and consumer ready pattern
  int cyc = 0;
  int rdy_mode = 0;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (cyc % 3 == 0);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // expected stream and observation state
  logic [7:0] exp_q[$];
  logic [3:0] addr_q[$];
  logic [7:0] model_csum;
  logic [7:0] exp_b;
  logic [7:0] prev_data;
  logic [3:0] last_addr;
  bit         stall_prev = 0;
  bit         saw_valid;
  int         n_done, n_hs, first_v, first_hs, last_hs, done_cyc;

  // Monitor, sampled on the falling edge away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("extra_byte", 32'(m_data), 32'hFFFF_FFFF);
        else begin
          exp_b = exp_q.pop_front();
          chk("byte", 32'(m_data), 32'(exp_b));
          model_csum = model_csum + exp_b;
        end
        if (n_hs == 0) first_hs = cyc;
        last_hs = cyc;
        n_hs++;
      end
      if (stall_prev && m_valid) chk("hold_stable", 32'(m_data), 32'(prev_data));
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      if (m_valid && !saw_valid) begin
        saw_valid = 1;
        first_v   = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (rom_addr != last_addr) begin
        addr_q.push_back(rom_addr);
        last_addr = rom_addr;
      end
    end else begin
      stall_prev = 0;
      last_addr  = rom_addr;
    end
  end

  task automatic clear_obs();
    exp_q.delete();
    addr_q.delete();
    n_done = 0; n_hs = 0; saw_valid = 0; model_csum = '0;
    first_v = 0; first_hs = 0; last_hs = 0; done_cyc = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"},    32'(busy),     0);
    chk({tag, "_done"},    32'(done),     0);
    chk({tag, "_rom_addr"},32'(rom_addr), 0);
    chk({tag, "_m_valid"}, 32'(m_valid),  0);
    chk({tag, "_m_data"},  32'(m_data),   0);
    chk({tag, "_csum"},    32'(csum),     0);
  endtask

  task automatic run_burst(input logic [3:0] b, input logic [4:0] l, input int mode, input bit again);
    logic [3:0] a0;
    logic [3:0] exp_addr[$];
    logic [3:0] a;
    int t0;
    int k;
    clear_obs();
    rdy_mode = mode;
    for (int i = 0; i < int'(l); i++) exp_q.push_back(rom_byte(b + 4'(i)));
    @(posedge clk); #1;
    a0 = rom_addr;
    for (int i = 0; i < int'(l); i++) begin
      a = b + 4'(i);
      if (!(i == 0 && a == a0)) exp_addr.push_back(a);
    end
    start = 1'b1; base = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    chk("busy_after_start", 32'(busy), 1);
    if (again) begin
      repeat (2) @(posedge clk);
      #1; start = 1'b1; base = 4'h7; len = 5'd5;
      @(posedge clk); #1; start = 1'b0;
    end
    k = 0;
    while (n_done == 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    chk("done_seen", 32'(n_done > 0), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once",  32'(n_done), 1);
    chk("byte_count", 32'(n_hs), 32'(l));
    chk("bytes_left", 32'(exp_q.size()), 0);
    chk("idle_after", 32'(busy), 0);
    chk("valid_seen", 32'(saw_valid), 32'(l != 0));
    if (l != 0) begin
      chk("first_valid_lat", 32'(first_v - t0), 5);
      chk("done_after_last", 32'(done_cyc > last_hs && done_cyc - last_hs <= 2), 1);
      if (mode == 0 && l <= 4) chk("back_to_back", 32'(last_hs - first_hs), 32'(int'(l) - 1));
    end else begin
      chk("len0_addr_hold", 32'(rom_addr), 32'(a0));
    end
    chk("addr_count", 32'(addr_q.size()), 32'(exp_addr.size()));
    for (int i = 0; i < addr_q.size() && i < exp_addr.size(); i++)
      chk("addr_seq", 32'(addr_q[i]), 32'(exp_addr[i]));
`ifdef ROM_RD_CHECKSUM_EN
    chk("csum", 32'(csum), 32'(model_csum));
`else
    chk("csum", 32'(csum), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base = '0; len = '0; m_ready = 1'b1;
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_burst(4'h0, 5'd4,  0, 0);
    run_burst(4'hF, 5'd3,  0, 0);
    run_burst(4'h0, 5'd16, 1, 0);
    run_burst(4'h9, 5'd0,  0, 0);

    // reset in the middle of a burst
    clear_obs();
    rdy_mode = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(rom_byte(4'h2 + 4'(i)));
    @(posedge clk); #1; start = 1'b1; base = 4'h2; len = 5'd8;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(posedge clk);
    #1; rst = 1'b1;
    #1; check_reset_vals("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    chk("midrst_no_done", 32'(n_done), 0);
    run_burst(4'h5, 5'd2, 0, 0);

    // second start while busy is ignored
    run_burst(4'h0, 5'd6, 0, 1);

    for (int r = 0; r < 8; r++)
      run_burst(4'($urandom_range(0, 15)), 5'($urandom_range(1, 16)), 2, 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
